// File: rtl/shared_bus_arbiter_pkg.sv
// Shared types and constants for the shared 4-bit bus arbiter.
// Tie-break mode is selected by ARB_ROUND_ROBIN_EN (see arb_pick2).
package shared_bus_arbiter_pkg;

    localparam int BUS_W = 4;

    localparam logic BUS_RELEASE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_XFER,
        ST_DONE
    } state_t;

endpackage

// File: rtl/shared_bus_arbiter_arb_pick2.sv
// Combinational two-request picker; winner index 0 or 1.
// ARB_ROUND_ROBIN_EN: ties go to the non-last owner, else req0 wins.
module arb_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick
);

`ifdef ARB_ROUND_ROBIN_EN
    assign pick = req1 & (~req0 | ~last);
`else
    logic unused_last;
    assign unused_last = last;
    assign pick = req1 & ~req0;
`endif

endmodule

// File: rtl/shared_bus_arbiter.sv
// Two-requester sequencer for the shared tristate bus (IDLE/TURN/XFER/DONE).
// Tie-break mode: define ARB_ROUND_ROBIN_EN for round robin, else fixed priority.
module shared_bus_arbiter
    import shared_bus_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             rw0,
    input  logic             rw1,
    input  logic [BUS_W-1:0] wdata0,
    input  logic [BUS_W-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [BUS_W-1:0] rdata,
    output logic [BUS_W-1:0] bus_dout,
    output logic             bus_we,
    input  logic [BUS_W-1:0] bus_din,
    output logic             bus_strobe
);

    localparam int unsigned HOLD_EFF  = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam logic [3:0]  HOLD_LOAD = 4'(HOLD_EFF - 1);

    state_t           state, next_state;
    logic [3:0]       cnt, next_cnt;
    logic             owner, next_owner;
    logic             rw, next_rw;
    logic [BUS_W-1:0] wdata, next_wdata;
    logic             pick;

    logic             gnt0_d, gnt1_d, done0_d, done1_d;
    logic             bus_we_d, strobe_d;
    logic [BUS_W-1:0] dout_d, rdata_d;
    logic             busy, wr_xfer;

    // owner doubles as the last-owner history for the tie-break
    arb_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (owner),
        .pick (pick)
    );

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_owner = owner;
        next_rw    = rw;
        next_wdata = wdata;
        unique case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    next_state = ST_TURN;
                    next_owner = pick;
                    next_rw    = pick ? rw1 : rw0;
                    next_wdata = pick ? wdata1 : wdata0;
                end
            end
            ST_TURN: begin
                next_state = ST_XFER;
                next_cnt   = HOLD_LOAD;
            end
            ST_XFER: begin
                if (cnt == 4'd0) next_state = ST_DONE;
                else             next_cnt   = cnt - 4'd1;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it
    always_comb begin
        busy     = (next_state == ST_TURN) || (next_state == ST_XFER);
        wr_xfer  = (next_state == ST_XFER) && next_rw;
        gnt0_d   = busy & ~next_owner;
        gnt1_d   = busy & next_owner;
        done0_d  = (next_state == ST_DONE) & ~next_owner;
        done1_d  = (next_state == ST_DONE) & next_owner;
        bus_we_d = wr_xfer ? ~BUS_RELEASE : BUS_RELEASE;
        dout_d   = wr_xfer ? next_wdata : '0;
        strobe_d = wr_xfer && (next_cnt == 4'd0);
        rdata_d  = rdata;
        if (state == ST_XFER && cnt == 4'd0 && !rw) rdata_d = bus_din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            owner      <= 1'b1;
            rw         <= 1'b0;
            wdata      <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata      <= '0;
            bus_dout   <= '0;
            bus_we     <= BUS_RELEASE;
            bus_strobe <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            owner      <= next_owner;
            rw         <= next_rw;
            wdata      <= next_wdata;
            gnt0       <= gnt0_d;
            gnt1       <= gnt1_d;
            done0      <= done0_d;
            done1      <= done1_d;
            rdata      <= rdata_d;
            bus_dout   <= dout_d;
            bus_we     <= bus_we_d;
            bus_strobe <= strobe_d;
        end
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter with HOLD_CYCLES=2.
// Contention expectations follow ARB_ROUND_ROBIN_EN.
module tb_shared_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, rw0, rw1;
    logic [3:0] wdata0, wdata1, bus_din;
    logic       gnt0, gnt1, done0, done1;
    logic [3:0] rdata, bus_dout;
    logic       bus_we, bus_strobe;

    int n_chk  = 0;
    int n_pass = 0;

    shared_bus_arbiter #(.HOLD_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .rw0        (rw0),
        .rw1        (rw1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .done0      (done0),
        .done1      (done1),
        .rdata      (rdata),
        .bus_dout   (bus_dout),
        .bus_we     (bus_we),
        .bus_din    (bus_din),
        .bus_strobe (bus_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic exp_own [3];

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_own[0] = 1'b0; exp_own[1] = 1'b1; exp_own[2] = 1'b0;
`else
        exp_own[0] = 1'b0; exp_own[1] = 1'b0; exp_own[2] = 1'b0;
`endif
        reset = 1'b0;
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
        wdata0 = 0; wdata1 = 0; bus_din = 0;

        // asynchronous reset, asserted between edges
        #2 reset = 1'b1;
        #1;
        check("rst_we", 8'(bus_we), 8'd1);
        check("rst_gnt", {gnt0, gnt1}, 8'd0);
        check("rst_done", {done0, done1}, 8'd0);
        check("rst_rdata", rdata, 8'd0);
        check("rst_dout", bus_dout, 8'd0);
        check("rst_strobe", 8'(bus_strobe), 8'd0);
        cyc();
        cyc();
        reset = 1'b0;

        // write by requester 0
        cyc();
        req0 = 1; rw0 = 1; wdata0 = 4'hA;
        check("w_c0_gnt", 8'(gnt0), 8'd0);
        cyc();
        wdata0 = 4'h3; rw0 = 0;
        check("w_c1_gnt", 8'(gnt0), 8'd1);
        check("w_c1_we", 8'(bus_we), 8'd1);
        check("w_c1_stb", 8'(bus_strobe), 8'd0);
        cyc();
        check("w_c2_gnt", 8'(gnt0), 8'd1);
        check("w_c2_we", 8'(bus_we), 8'd0);
        check("w_c2_dout", bus_dout, 8'hA);
        check("w_c2_stb", 8'(bus_strobe), 8'd0);
        cyc();
        check("w_c3_gnt", 8'(gnt0), 8'd1);
        check("w_c3_we", 8'(bus_we), 8'd0);
        check("w_c3_dout", bus_dout, 8'hA);
        check("w_c3_stb", 8'(bus_strobe), 8'd1);
        cyc();
        check("w_c4_done", {done0, done1}, 8'b10);
        check("w_c4_gnt", {gnt0, gnt1}, 8'd0);
        check("w_c4_we", 8'(bus_we), 8'd1);
        check("w_c4_dout", bus_dout, 8'd0);
        check("w_c4_stb", 8'(bus_strobe), 8'd0);
        req0 = 0;
        cyc();
        check("w_c5_done", {done0, done1}, 8'd0);

        // read by requester 1
        req1 = 1; rw1 = 0;
        cyc();
        check("r_c1_gnt", {gnt0, gnt1}, 8'b01);
        check("r_c1_we", 8'(bus_we), 8'd1);
        bus_din = 4'hF;
        cyc();
        check("r_c2_we", 8'(bus_we), 8'd1);
        bus_din = 4'h5;
        cyc();
        check("r_c3_we", 8'(bus_we), 8'd1);
        check("r_c3_rdata", rdata, 8'd0);
        cyc();
        check("r_c4_rdata", rdata, 8'h5);
        check("r_c4_done", {done0, done1}, 8'b01);
        check("r_c4_we", 8'(bus_we), 8'd1);
        req1 = 0;
        bus_din = 4'h9;
        cyc();
        check("r_c5_rdata", rdata, 8'h5);
        check("r_c5_done", {done0, done1}, 8'd0);

        // contention: both held for three transactions
        req0 = 1; req1 = 1; rw0 = 1; rw1 = 1;
        wdata0 = 4'h1; wdata1 = 4'h2;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("arb%0d_gnt", k), {gnt0, gnt1},
                  exp_own[k] ? 8'b01 : 8'b10);
            cyc();
            check($sformatf("arb%0d_dout", k), bus_dout,
                  exp_own[k] ? 8'h2 : 8'h1);
            cyc();
            cyc();
            check($sformatf("arb%0d_done", k), {done0, done1},
                  exp_own[k] ? 8'b01 : 8'b10);
            if (k == 2) begin
                req0 = 0; req1 = 0;
            end
            cyc();
        end
        check("arb_idle_gnt", {gnt0, gnt1}, 8'd0);

        // owner drops req0 in first XFER cycle
        req0 = 1; rw0 = 1; wdata0 = 4'h6;
        cyc();
        check("drop_c1_gnt", 8'(gnt0), 8'd1);
        cyc();
        req0 = 0;
        check("drop_c2_dout", bus_dout, 8'h6);
        cyc();
        check("drop_c3_stb", 8'(bus_strobe), 8'd1);
        cyc();
        check("drop_c4_done", 8'(done0), 8'd1);
        cyc();
        check("drop_c5_done", 8'(done0), 8'd0);

        // reset pulsed during a write XFER
        req0 = 1; rw0 = 1; wdata0 = 4'hC;
        cyc();
        cyc();
        check("rx_c2_we", 8'(bus_we), 8'd0);
        check("rx_c2_dout", bus_dout, 8'hC);
        #2 reset = 1'b1;
        #1;
        check("rx_we", 8'(bus_we), 8'd1);
        check("rx_gnt", {gnt0, gnt1}, 8'd0);
        check("rx_dout", bus_dout, 8'd0);
        check("rx_stb", 8'(bus_strobe), 8'd0);
        check("rx_rdata", rdata, 8'd0);
        req0 = 0;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("rx_nodone%0d", i), {done0, done1}, 8'd0);
        end

        // subsequent read completes normally
        req0 = 1; rw0 = 0;
        cyc();
        check("rr_c1_gnt", {gnt0, gnt1}, 8'b10);
        cyc();
        bus_din = 4'h7;
        cyc();
        check("rr_c3_we", 8'(bus_we), 8'd1);
        cyc();
        check("rr_c4_rdata", rdata, 8'h7);
        check("rr_c4_done", {done0, done1}, 8'b10);
        req0 = 0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/shared_bus_arbiter.md
# shared_bus_arbiter

Sequencer and arbiter for the shared 4-bit bidirectional data bus. It grants the bus to one of two requesters and drives the tristate bus cell's write-enable, with a mandatory turnaround cycle before each transfer. For writes it drives the bus; for reads it samples the bus. It sits between the two requester blocks and the bus's tristate buffer cell, which it controls through `bus_we`.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1: data-phase length in clocks. Legal range 1–15; 0 is treated as 1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  transaction request, held until matching `done`.
- `rw0`, `rw1`  in  1  1 = write (controller drives bus), 0 = read.
- `wdata0`, `wdata1`  in  4  write data; sampled at grant.
- `gnt0`, `gnt1`  out  1  requester owns the bus.
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `rdata`  out  4  last read value; held until the next read completes.
- `bus_dout`  out  4  value to drive onto the bus.
- `bus_we`  out  1  bus-cell enable: 1 = bus released (high-Z, input), 0 = drive `bus_dout`.
- `bus_din`  in  4  value currently on the bus.
- `bus_strobe`  out  1  write-commit strobe to the bus target.

## Operation
- FSM states and transitions:
  - IDLE → TURN when any `req` is high; the owner is latched at this transition.
  - TURN → XFER after 1 cycle.
  - XFER → DONE after `HOLD_CYCLES` cycles, counted by a 4-bit down-counter.
  - DONE → IDLE after 1 cycle.
- Grant select:
  - Only one request high: that requester wins.
  - Both requests high: the rule in Configuration applies.
- At the IDLE→TURN edge, the controller latches the owner, its `rw`, and its `wdata`. Later changes on these inputs have no effect until the transaction completes.
- `gnt<owner>` is high in TURN and XFER and low otherwise. Both grants are never high at the same time.
- In TURN, `bus_we` = 1, regardless of direction.
- In XFER for a write:
  - `bus_we` = 0.
  - `bus_dout` = the latched `wdata`.
  - `bus_strobe` = 1 only in the last XFER cycle.
- In XFER for a read:
  - `bus_we` = 1.
  - `bus_din` is captured into `rdata` at the end of the last XFER cycle.
- In DONE:
  - `done<owner>` = 1.
  - `bus_we` = 1.
  - `bus_dout` returns to 0.
- If the owner drops `req` during TURN or XFER, the transaction still completes and `done` still pulses.
- `bus_we` = 1 in every state except write-XFER.

## Timing
- All outputs are registered, except that reset clears them asynchronously.
- Reset values:
  - `gnt0`, `gnt1`, `done0`, `done1` = 0.
  - `rdata` = 0, `bus_dout` = 0.
  - `bus_we` = 1, `bus_strobe` = 0.
  - State = IDLE; last owner = 1, so requester 0 wins the first tie.
- Cycle numbering, with `req` first high in cycle 0 while in IDLE:
  - TURN in cycle 1.
  - XFER in cycles 2 … `HOLD_CYCLES`+1.
  - DONE in cycle `HOLD_CYCLES`+2.
  - IDLE in cycle `HOLD_CYCLES`+3; a new grant is possible from the next cycle.
- Back-to-back transactions occupy a minimum of `HOLD_CYCLES`+3 cycles each.
- `rdata` is valid in the DONE cycle and stays stable afterwards.
- Reset mid-transaction:
  - The bus is released immediately.
  - No `done` pulse is produced.
  - The interrupted request must be re-arbitrated after reset.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a tie, the requester that is not the last owner wins. Last owner updates at each grant.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, `req0` always wins ties. The last-owner register is not built.

## Structure
- Shared header/package:
  - FSM state encodings (IDLE, TURN, XFER, DONE).
  - Constant `BUS_RELEASE` = 1 for the `bus_we` idle level.
  - Bus width = 4.
- One natural sub-module, `arb_pick2`: combinational two-request picker. Inputs are the requests and the last owner; output is the winner index. The `ARB_ROUND_ROBIN_EN` switch lives inside it.

## Test plan
- Reset check: assert `reset` mid-cycle → `bus_we`=1, `gnt0`=`gnt1`=0, `done0`=`done1`=0, `rdata`=0, `bus_strobe`=0, all asynchronously.
- Write by requester 0 (`HOLD_CYCLES`=2, `req0`=1, `rw0`=1, `wdata0`=4'hA in cycle 0):
  - `gnt0` high in cycles 1–3.
  - `bus_we`=1 in cycle 1, then 0 in cycles 2–3 with `bus_dout`=4'hA.
  - `bus_strobe` high in cycle 3 only.
  - `done0` high in cycle 4.
- Read by requester 1 (`HOLD_CYCLES`=2, `req1`=1, `rw1`=0, `bus_din`=4'h5 in cycle 3):
  - `bus_we`=1 throughout.
  - `rdata`=4'h5 from cycle 4.
  - `done1` high in cycle 4.
- Contention, both requests held continuously for three transactions:
  - With `ARB_ROUND_ROBIN_EN`: grants go 0, 1, 0.
  - Without it: grants go 0, 0, 0.
- Owner drops `req0` in the first XFER cycle → the write still completes, with `done0` pulsing in cycle `HOLD_CYCLES`+2.
- Reset pulsed during a write XFER:
  - `bus_we` returns to 1 immediately and no `done` pulses.
  - A subsequent read completes normally.
